// File: rtl/arp_sequencer.sv
// Step-sequenced arpeggiator: 8-entry key pattern played up/down/ping-pong/hold
// with a prescaled step timer, gate timing and saturated transpose.
module arp_sequencer #(
  parameter int PRESCALE = 25000
) (
  input  logic       clk25_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [1:0] mode_i,
  input  logic [2:0] len_i,
  input  logic [9:0] step_ms_i,
  input  logic [9:0] gate_ms_i,
  input  logic [5:0] transpose_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [6:0] wr_key_i,
  output logic [6:0] k_o,
  output logic       gate_o,
  output logic       step_strobe_o,
  output logic [2:0] step_idx_o,
  output logic       busy_o
);
  typedef logic [6:0] key_t;

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  logic [0:0]    state_q, state_d;
  key_t          pat_q [8];
  logic          dir_up_q, dir_up_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    tick_q, tick_d;
  logic [9:0]    step_ms_q, step_ms_d;
  logic [9:0]    gate_ms_q, gate_ms_d;
  logic [2:0]    idx_q, idx_d;
  key_t          k_q, k_d;
  logic          gate_q, gate_d;
  logic          strobe_q, strobe_d;

  logic        pre_wrap, step_end, start, ndir;
  logic [9:0]  tick_nxt;
  logic [2:0]  nidx;
  key_t        key_rd, key_sat;
  logic signed [8:0] sum;

  // Index the upcoming step will use, evaluated with the parameters sampled now.
  always_comb begin
    nidx = 3'd0;
    ndir = dir_up_q;
    if (state_q == IDLE || idx_q > len_i) begin
      nidx = (mode_i == 2'd1) ? len_i : 3'd0;
      ndir = 1'b1;
    end else begin
      case (mode_i)
        2'd0: nidx = (idx_q == len_i) ? 3'd0 : idx_q + 3'd1;
        2'd1: nidx = (idx_q == 3'd0) ? len_i : idx_q - 3'd1;
        2'd2: begin
          if (len_i == 3'd0) begin
            nidx = 3'd0;
          end else if (dir_up_q) begin
            if (idx_q == len_i) begin
              nidx = idx_q - 3'd1;
              ndir = 1'b0;
            end else begin
              nidx = idx_q + 3'd1;
            end
          end else if (idx_q == 3'd0) begin
            nidx = 3'd1;
            ndir = 1'b1;
          end else begin
            nidx = idx_q - 3'd1;
          end
        end
        default: nidx = 3'd0;
      endcase
    end
  end

  // Same-cycle write to the address being read wins over the stored entry.
  always_comb begin
    key_rd = (wr_en_i && wr_addr_i == nidx) ? wr_key_i : pat_q[nidx];
    sum    = $signed({2'b00, key_rd}) + $signed({{3{transpose_i[5]}}, transpose_i});
    if (sum[8])             key_sat = 7'd0;
    else if (sum > 9'sd127) key_sat = 7'd127;
    else                    key_sat = sum[6:0];
  end

  always_comb begin
    pre_wrap  = (pre_q == PRE_LAST);
    tick_nxt  = pre_wrap ? tick_q + 10'd1 : tick_q;
    step_end  = pre_wrap && (tick_q == step_ms_q - 10'd1);
    start     = run_i && (state_q == IDLE || step_end);
    state_d   = run_i ? PLAY : IDLE;
    dir_up_d  = dir_up_q;
    pre_d     = pre_q;
    tick_d    = tick_q;
    step_ms_d = step_ms_q;
    gate_ms_d = gate_ms_q;
    idx_d     = idx_q;
    k_d       = k_q;
    gate_d    = 1'b0;
    strobe_d  = 1'b0;
    if (start) begin
      dir_up_d  = ndir;
      idx_d     = nidx;
      k_d       = key_sat;
      gate_d    = (gate_ms_i != 10'd0);
      strobe_d  = 1'b1;
      pre_d     = '0;
      tick_d    = 10'd0;
      step_ms_d = (step_ms_i == 10'd0) ? 10'd1 : step_ms_i;
      gate_ms_d = gate_ms_i;
    end else if (state_q == PLAY && run_i) begin
      pre_d  = pre_wrap ? '0 : pre_q + PW'(1);
      tick_d = tick_nxt;
      gate_d = (tick_nxt < gate_ms_q);
    end
  end

  always_ff @(posedge clk25_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dir_up_q  <= 1'b1;
      pre_q     <= '0;
      tick_q    <= 10'd0;
      step_ms_q <= 10'd0;
      gate_ms_q <= 10'd0;
      idx_q     <= 3'd0;
      k_q       <= 7'd0;
      gate_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_up_q  <= dir_up_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      step_ms_q <= step_ms_d;
      gate_ms_q <= gate_ms_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      gate_q    <= gate_d;
      strobe_q  <= strobe_d;
    end
  end

  always_ff @(posedge clk25_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) pat_q[i] <= 7'd0;
    end else if (wr_en_i) begin
      pat_q[wr_addr_i] <= wr_key_i;
    end
  end

  assign k_o           = k_q;
  assign gate_o        = gate_q;
  assign step_strobe_o = strobe_q;
  assign step_idx_o    = idx_q;
  assign busy_o        = (state_q == PLAY);
endmodule

// File: tb/tb_arp_sequencer.sv
// Directed bench for arp_sequencer at PRESCALE=4 (one tick = 4 clocks).
module tb_arp_sequencer;
  logic       clk = 1'b0;
  logic       rst, run, wr_en, gate, strobe, busy;
  logic [1:0] mode;
  logic [2:0] len, wr_addr, idx;
  logic [9:0] step_ms, gate_ms;
  logic [5:0] trans;
  logic [6:0] wr_key, k;

  int n_chk = 0;
  int n_pass = 0;
  int c, g, sc;
  int exp_up[5]   = '{44, 47, 52, 40, 44};
  int exp_pp[7]   = '{1, 2, 3, 2, 1, 0, 1};
  int exp_down[4] = '{2, 1, 0, 3};

  arp_sequencer #(.PRESCALE(4)) dut (
    .clk25_i(clk), .rst_i(rst), .run_i(run), .mode_i(mode), .len_i(len),
    .step_ms_i(step_ms), .gate_ms_i(gate_ms), .transpose_i(trans),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_key_i(wr_key),
    .k_o(k), .gate_o(gate), .step_strobe_o(strobe), .step_idx_o(idx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] v);
    wr_en = 1'b1; wr_addr = a; wr_key = v;
    step();
    wr_en = 1'b0;
  endtask

  // Advance to the next step strobe; cyc = clocks taken, ghi = gate-high clocks seen
  // from the current cycle up to (not including) the new strobe.
  task automatic next_step(output int cyc, output int ghi);
    cyc = 0;
    ghi = int'(gate);
    do begin
      step();
      cyc++;
      if (!strobe) ghi += int'(gate);
    end while (!strobe && cyc < 100);
    chk("strobe_seen", int'(strobe), 1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_key = 7'd0;
    mode = 2'd0; len = 3'd3; step_ms = 10'd2; gate_ms = 10'd1; trans = 6'd0;
    step(); step();
    chk("rst_k", int'(k), 0);
    chk("rst_gate", int'(gate), 0);
    chk("rst_strobe", int'(strobe), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();
    chk("idle_busy", int'(busy), 0);

    wr(3'd0, 7'd40); wr(3'd1, 7'd44); wr(3'd2, 7'd47); wr(3'd3, 7'd52);
    run = 1'b1;
    next_step(c, g);
    chk("first_latency", c, 1);
    chk("play_busy", int'(busy), 1);
    chk("up_k0", int'(k), 40);
    chk("up_idx0", int'(idx), 0);
    chk("up_gate0", int'(gate), 1);
    for (int i = 0; i < 5; i++) begin
      next_step(c, g);
      chk("up_k", int'(k), exp_up[i]);
      chk("up_period", c, 8);
      chk("up_gate_cycles", g, 4);
    end

    run = 1'b0; step();
    chk("stop_busy", int'(busy), 0);
    mode = 2'd2; run = 1'b1;
    next_step(c, g);
    chk("pp_idx0", int'(idx), 0);
    for (int i = 0; i < 7; i++) begin
      next_step(c, g);
      chk("pp_idx", int'(idx), exp_pp[i]);
    end

    run = 1'b0; step();
    mode = 2'd1; run = 1'b1;
    next_step(c, g);
    chk("down_idx0", int'(idx), 3);
    for (int i = 0; i < 4; i++) begin
      next_step(c, g);
      chk("down_idx", int'(idx), exp_down[i]);
    end

    step();
    run = 1'b0; step();
    chk("stop_gate", int'(gate), 0);
    chk("stop_busy2", int'(busy), 0);
    chk("stop_k_held", int'(k), 52);
    chk("stop_idx_held", int'(idx), 3);
    chk("stop_no_strobe", int'(strobe), 0);
    mode = 2'd0; run = 1'b1; step();
    chk("restart_strobe", int'(strobe), 1);
    chk("restart_idx", int'(idx), 0);
    chk("restart_k", int'(k), 40);
    run = 1'b0; step();

    wr(3'd0, 7'd125);
    mode = 2'd3; len = 3'd0; trans = 6'd5; run = 1'b1;
    next_step(c, g);
    chk("sat_hi", int'(k), 127);
    wr(3'd0, 7'd2);
    trans = 6'h3B;
    next_step(c, g);
    chk("sat_lo", int'(k), 0);
    trans = 6'd0;
    next_step(c, g);
    chk("no_transpose", int'(k), 2);

    gate_ms = 10'd5;
    next_step(c, g);
    next_step(c, g);
    chk("gate_long_cycles", g, 8);
    chk("gate_long_at_strobe", int'(gate), 1);
    gate_ms = 10'd0;
    next_step(c, g);
    next_step(c, g);
    chk("gate_zero_cycles", g, 0);
    step_ms = 10'd0;
    next_step(c, g);
    chk("period_before_zero", c, 8);
    next_step(c, g);
    chk("period_zero_a", c, 4);
    next_step(c, g);
    chk("period_zero_b", c, 4);
    step_ms = 10'd2; gate_ms = 10'd1;
    run = 1'b0; step();

    for (int i = 0; i < 8; i++) wr(3'(i), 7'(10 + i));
    mode = 2'd0; len = 3'd7; run = 1'b1;
    next_step(c, g);
    chk("len_idx0", int'(idx), 0);
    for (int i = 0; i < 5; i++) next_step(c, g);
    chk("len_idx5", int'(idx), 5);
    chk("len_k5", int'(k), 15);
    len = 3'd1;
    next_step(c, g);
    chk("len_shrink_idx", int'(idx), 0);
    chk("len_shrink_k", int'(k), 10);
    for (int i = 0; i < 7; i++) step();
    wr_en = 1'b1; wr_addr = 3'd1; wr_key = 7'd99;
    step();
    wr_en = 1'b0;
    chk("bypass_strobe", int'(strobe), 1);
    chk("bypass_idx", int'(idx), 1);
    chk("bypass_k", int'(k), 99);
    next_step(c, g);
    next_step(c, g);
    chk("stored_k", int'(k), 99);

    step(); step();
    rst = 1'b1;
    #1;
    chk("arst_k", int'(k), 0);
    chk("arst_gate", int'(gate), 0);
    chk("arst_strobe", int'(strobe), 0);
    chk("arst_idx", int'(idx), 0);
    chk("arst_busy", int'(busy), 0);
    sc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      sc += int'(strobe);
    end
    chk("rst_held_strobes", sc, 0);
    rst = 1'b0;
    next_step(c, g);
    chk("resume_latency", c, 1);
    chk("resume_k_cleared", int'(k), 0);
    next_step(c, g);
    chk("resume_idx1", int'(idx), 1);
    chk("resume_k1_cleared", int'(k), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
